// File: rtl/mem_stage_pkg.sv
// Shared widths, funct3 encodings, FSM states and pipeline register layouts for mem_stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int REG_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic                      valid;
    logic [REG_WIDTH-1:0]      alu;
    logic [REG_WIDTH-1:0]      sdata;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      we;
    logic                      mem_rd;
    logic                      mem_wr;
    logic [2:0]                funct3;
  } ex_mem_t;

  typedef struct packed {
    logic                      we;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_WIDTH-1:0]      data;
  } mem_wb_t;

  // Access size from funct3[1:0]; unknown encodings behave as a word access.
  function automatic acc_size_e acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and data memory.
// Latency: n/a (wires only).
// Backpressure: req is held with stable payload until gnt; rvalid returns load data later.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                 req;
  logic                 we;
  logic [REG_WIDTH-1:0] addr;
  logic [3:0]           be;
  logic [REG_WIDTH-1:0] wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [REG_WIDTH-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_stage_load_store_align.sv
// Byte-lane steering: store byte enables/replication, load lane extraction, misalignment detect.
// Latency: purely combinational.
// Backpressure: none.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [REG_WIDTH-1:0] store_data_i,
  input  logic [REG_WIDTH-1:0] rdata_i,
  output logic [3:0]           be_o,
  output logic [REG_WIDTH-1:0] wdata_o,
  output logic [REG_WIDTH-1:0] load_data_o,
  output logic                 misaligned_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Store lane replication, byte enables and alignment check by access size
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = '0;
    misaligned_o = 1'b0;
    case (acc_size(funct3_i))
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        be_o         = 4'b1111;
        wdata_o      = store_data_i;
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

  // Pick the addressed byte and halfword out of the returned word
  always_comb begin
    byte_lane = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Sign/zero extension; unlisted funct3 values pass the full word like lw
  always_comb begin
    load_data_o = rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data_o = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_data_o = {24'h0, byte_lane};
      F3_HU:   load_data_o = {16'h0, half_lane};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM register, data-memory handshake FSM, MEM/WB register, forwarding taps.
// Latency: 1 cycle for ALU ops and stores granted at once; loads take at least 2 (gnt, then rvalid).
// Backpressure: mem_stall (combinational) freezes upstream and EX/MEM until the access completes.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic [REG_WIDTH-1:0]      ex_alu_result,
  input  logic [REG_WIDTH-1:0]      ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_we,
  input  logic                      ex_mem_rd,
  input  logic                      ex_mem_wr,
  input  logic [2:0]                ex_funct3,
  mem_stage_if.master               dmem,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_mem,
  output logic [REG_WIDTH-1:0]      rd_data_mem,
  output logic                      we_mem,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_wb,
  output logic [REG_WIDTH-1:0]      rd_data_wb,
  output logic                      we_wb,
  output logic                      mem_stall,
  output logic                      mem_misaligned
);

  ex_mem_t    exm_q, exm_d;
  mem_wb_t    mwb_q, mwb_d;
  mem_state_e state_q, state_d;

  logic                 req;
  logic                 done;
  logic                 mem_op;
  logic                 mem_go;
  logic [3:0]           be_raw;
  logic [REG_WIDTH-1:0] wdata_raw;
  logic [REG_WIDTH-1:0] load_data;
  logic                 mis_raw;

  load_store_align u_align (
    .funct3_i     (exm_q.funct3),
    .addr_lo_i    (exm_q.alu[1:0]),
    .store_data_i (exm_q.sdata),
    .rdata_i      (dmem.rdata),
    .be_o         (be_raw),
    .wdata_o      (wdata_raw),
    .load_data_o  (load_data),
    .misaligned_o (mis_raw)
  );

  // A misaligned op never issues, so it never stalls and retires as a bubble
  assign mem_op         = exm_q.valid & (exm_q.mem_rd | exm_q.mem_wr);
  assign mem_go         = mem_op & ~mis_raw;
  assign mem_stall      = mem_go & ~done;
  assign mem_misaligned = mem_op & mis_raw & (state_q == IDLE);

  // Request payload comes straight from EX/MEM, so it cannot move while waiting for gnt
  assign dmem.req   = req;
  assign dmem.we    = mem_op & exm_q.mem_wr & ~exm_q.mem_rd;
  assign dmem.addr  = {exm_q.alu[REG_WIDTH-1:2], 2'b00};
  assign dmem.be    = mem_op ? be_raw : 4'b0000;
  assign dmem.wdata = wdata_raw;

  // Load results do not exist yet in MEM, so loads are not forwarded from here
  assign rd_addr_mem = exm_q.rd;
  assign rd_data_mem = exm_q.alu;
  assign we_mem      = exm_q.we & ~exm_q.mem_rd;
  assign rd_addr_wb  = mwb_q.rd;
  assign rd_data_wb  = mwb_q.data;
  assign we_wb       = mwb_q.we;

  // EX/MEM next state: hold during a stall; writes to x0 are dropped at capture
  always_comb begin
    exm_d = exm_q;
    if (!mem_stall) begin
      exm_d.valid  = ex_valid;
      exm_d.alu    = ex_alu_result;
      exm_d.sdata  = ex_store_data;
      exm_d.rd     = ex_rd_addr;
      exm_d.we     = ex_valid & ex_we & (ex_rd_addr != '0);
      exm_d.mem_rd = ex_mem_rd;
      exm_d.mem_wr = ex_mem_wr;
      exm_d.funct3 = ex_funct3;
    end
  end

  // Handshake FSM: req until gnt; stores finish on gnt, loads wait for rvalid
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE, WAIT_GNT: begin
        if (mem_go) begin
          req = 1'b1;
          if (dmem.gnt) begin
            if (exm_q.mem_rd) state_d = WAIT_RVALID;
            else begin
              done    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_RVALID: begin
        if (dmem.rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB next state: retire the instruction when not stalled, else insert a bubble
  always_comb begin
    mwb_d    = mwb_q;
    mwb_d.we = 1'b0;
    if (!mem_stall) begin
      mwb_d.rd   = exm_q.rd;
      mwb_d.data = exm_q.mem_rd ? load_data : exm_q.alu;
      mwb_d.we   = exm_q.we & ~(mem_op & mis_raw);
    end
  end

  // Pipeline registers and FSM state; reset abandons any outstanding access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_q   <= '0;
      mwb_q   <= '0;
      state_q <= IDLE;
    end else begin
      exm_q   <= exm_d;
      mwb_q   <= mwb_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, misalignment, mid-access reset.
// Latency: n/a.
// Backpressure: memory responses are driven per vector.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_we;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [2:0]  ex_funct3;
  logic [4:0]  rd_addr_mem;
  logic [31:0] rd_data_mem;
  logic        we_mem;
  logic [4:0]  rd_addr_wb;
  logic [31:0] rd_data_wb;
  logic        we_wb;
  logic        mem_stall;
  logic        mem_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_if dmem ();

  always #5 clk = ~clk;

  mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_rd_addr     (ex_rd_addr),
    .ex_we          (ex_we),
    .ex_mem_rd      (ex_mem_rd),
    .ex_mem_wr      (ex_mem_wr),
    .ex_funct3      (ex_funct3),
    .dmem           (dmem),
    .rd_addr_mem    (rd_addr_mem),
    .rd_data_mem    (rd_data_mem),
    .we_mem         (we_mem),
    .rd_addr_wb     (rd_addr_wb),
    .rd_data_wb     (rd_data_wb),
    .we_wb          (we_wb),
    .mem_stall      (mem_stall),
    .mem_misaligned (mem_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_op(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic we, input logic mrd,
                       input logic mwr, input logic [2:0] f3);
    ex_valid      = v;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rd_addr    = rd;
    ex_we         = we;
    ex_mem_rd     = mrd;
    ex_mem_wr     = mwr;
    ex_funct3     = f3;
  endtask

  task automatic ex_idle();
    ex_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  // Load with gnt in the first MEM cycle and rvalid in the next
  task automatic load_fast(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    ex_op(1'b1, addr, 32'h0, rd, 1'b1, 1'b1, 1'b0, f3);
    dmem.gnt = 1'b1;
    tick();
    ex_idle();
    #1;
    chk({tag, "_stall_n"}, 32'(mem_stall), 32'd1);
    chk({tag, "_req"}, 32'(dmem.req), 32'd1);
    chk({tag, "_addr"}, dmem.addr, {addr[31:2], 2'b00});
    chk({tag, "_we_mem"}, 32'(we_mem), 32'd0);
    tick();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = rdata;
    #1;
    chk({tag, "_stall_n1"}, 32'(mem_stall), 32'd0);
    chk({tag, "_req_n1"}, 32'(dmem.req), 32'd0);
    tick();
    dmem.rvalid = 1'b0;
    chk({tag, "_wb_data"}, rd_data_wb, exp);
    chk({tag, "_wb_we"}, 32'(we_wb), 32'd1);
    chk({tag, "_wb_rd"}, 32'(rd_addr_wb), 32'(rd));
  endtask

  initial begin
    rst_n       = 1'b0;
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = 32'h0;
    ex_op(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7, 1'b1, 1'b0, 1'b1, 3'b001);
    #1;
    chk("rst_req", 32'(dmem.req), 32'd0);
    chk("rst_be", 32'(dmem.be), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_rd_mem", 32'(rd_addr_mem), 32'd0);
    chk("rst_we_wb", 32'(we_wb), 32'd0);
    tick();
    chk("rst_hold_data_mem", rd_data_mem, 32'h0);
    ex_idle();
    #4 rst_n = 1'b1;
    tick();

    // ALU op then an x0 write
    ex_op(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    chk("alu_rd_mem", 32'(rd_addr_mem), 32'd5);
    chk("alu_we_mem", 32'(we_mem), 32'd1);
    chk("alu_data_mem", rd_data_mem, 32'h0000_1234);
    chk("alu_stall", 32'(mem_stall), 32'd0);
    ex_op(1'b1, 32'h0000_0055, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    chk("x0_we_mem", 32'(we_mem), 32'd0);
    chk("alu_wb_data", rd_data_wb, 32'h0000_1234);
    chk("alu_wb_we", 32'(we_wb), 32'd1);
    chk("alu_wb_rd", 32'(rd_addr_wb), 32'd5);
    ex_idle();
    tick();
    chk("x0_we_wb", 32'(we_wb), 32'd0);

    load_fast("lb", 32'h0000_0103, F3_B, 5'd7, 32'h80AA_BBCC, 32'hFFFF_FF80);
    load_fast("lhu", 32'h0000_0102, F3_HU, 5'd8, 32'h80AA_BBCC, 32'h0000_80AA);
    load_fast("lh", 32'h0000_0102, F3_H, 5'd9, 32'h80AA_BBCC, 32'hFFFF_80AA);
    load_fast("lbu", 32'h0000_0101, F3_BU, 5'd10, 32'h80AA_BBCC, 32'h0000_00BB);
    load_fast("lw", 32'h0000_0104, F3_W, 5'd11, 32'h80AA_BBCC, 32'h80AA_BBCC);

    // sh with gnt three cycles late: payload must hold steady
    ex_op(1'b1, 32'h0000_0102, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, F3_H);
    dmem.gnt = 1'b0;
    tick();
    ex_idle();
    for (int i = 0; i < 4; i++) begin
      dmem.gnt = (i == 3);
      #1;
      chk($sformatf("sh_stall_c%0d", i), 32'(mem_stall), (i == 3) ? 32'd0 : 32'd1);
      chk($sformatf("sh_req_c%0d", i), 32'(dmem.req), 32'd1);
      chk($sformatf("sh_addr_c%0d", i), dmem.addr, 32'h0000_0100);
      chk($sformatf("sh_be_c%0d", i), 32'(dmem.be), 32'hC);
      chk($sformatf("sh_wdata_c%0d", i), dmem.wdata, 32'hBEEF_BEEF);
      chk($sformatf("sh_we_c%0d", i), 32'(dmem.we), 32'd1);
      tick();
    end
    dmem.gnt = 1'b0;
    #1;
    chk("sh_req_after", 32'(dmem.req), 32'd0);

    // sb and sw granted immediately: no stall
    ex_op(1'b1, 32'h0000_0101, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, F3_B);
    dmem.gnt = 1'b1;
    tick();
    ex_op(1'b1, 32'h0000_0108, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, F3_W);
    #1;
    chk("sb_stall", 32'(mem_stall), 32'd0);
    chk("sb_be", 32'(dmem.be), 32'h2);
    chk("sb_wdata", dmem.wdata, 32'h7878_7878);
    tick();
    ex_idle();
    #1;
    chk("sw_stall", 32'(mem_stall), 32'd0);
    chk("sw_be", 32'(dmem.be), 32'hF);
    chk("sw_wdata", dmem.wdata, 32'hCAFE_F00D);
    chk("sw_addr", dmem.addr, 32'h0000_0108);
    tick();
    dmem.gnt = 1'b0;

    // Misaligned lw: no request, one-cycle pulse, bubble in WB
    ex_op(1'b1, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, F3_W);
    tick();
    ex_idle();
    #1;
    chk("mis_pulse", 32'(mem_misaligned), 32'd1);
    chk("mis_req", 32'(dmem.req), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(mem_misaligned), 32'd0);
    chk("mis_we_wb", 32'(we_wb), 32'd0);

    // Reset while waiting for rvalid
    ex_op(1'b1, 32'h0000_ABCD, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    ex_op(1'b1, 32'h0000_0200, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, F3_W);
    dmem.gnt = 1'b1;
    tick();
    ex_idle();
    #1;
    chk("rstw_stall", 32'(mem_stall), 32'd1);
    chk("rstw_wb_pre", rd_data_wb, 32'h0000_ABCD);
    tick();
    dmem.gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_rd_mem", 32'(rd_addr_mem), 32'd0);
    chk("rstw_data_mem", rd_data_mem, 32'h0);
    chk("rstw_rd_wb", 32'(rd_addr_wb), 32'd0);
    chk("rstw_data_wb", rd_data_wb, 32'h0);
    chk("rstw_stall0", 32'(mem_stall), 32'd0);
    chk("rstw_req", 32'(dmem.req), 32'd0);
    #2 rst_n = 1'b1;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'hDEAD_BEEF;
    tick();
    dmem.rvalid = 1'b0;
    chk("rstw_late_we_wb", 32'(we_wb), 32'd0);
    chk("rstw_late_data_wb", rd_data_wb, 32'h0);

    // Reset while waiting for gnt: req must drop without a clock edge
    ex_op(1'b1, 32'h0000_0300, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, F3_W);
    tick();
    ex_idle();
    tick();
    chk("rstg_req_pre", 32'(dmem.req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstg_req", 32'(dmem.req), 32'd0);
    chk("rstg_addr", dmem.addr, 32'h0);
    #2 rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
